// File: rtl/eth_fcs_pkg.sv
// Shared constants and helpers for the Ethernet FCS (CRC-32) stream tap.
// Reflected CRC-32 as used by IEEE 802.3: init all-ones, final inversion,
// and a good frame (FCS included) leaves the register at the residue.
package eth_fcs_pkg;

    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    // Widest tkeep supported (DATA_WIDTH up to 512 bits).
    localparam int KEEP_MAX = 64;

    typedef enum logic [0:0] {
        FRAME_IDLE = 1'b0,
        FRAME_IN   = 1'b1
    } frame_state_e;

    // Number of contiguous ones starting at the tkeep LSB (0..KEEP_MAX).
    function automatic logic [6:0] keep_to_count(input logic [KEEP_MAX-1:0] keep);
        logic [6:0] n;
        logic       run;
        n   = 7'd0;
        run = 1'b1;
        for (int i = 0; i < KEEP_MAX; i++) begin
            if (run && keep[i]) begin
                n = n + 7'd1;
            end else begin
                run = 1'b0;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/axis_eth_fcs_param_lfsr.sv
// Combinational Galois LFSR step over DATA_WIDTH input bits.
// REVERSE=1 runs the register reflected (data LSB first), which is the
// bit order Ethernet uses for its CRC-32.
module lfsr #(
    parameter int                    LFSR_WIDTH = 32,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY  = 32'h04C11DB7,
    parameter int                    REVERSE    = 1,
    parameter int                    DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [LFSR_WIDTH-1:0] state_cur,
    output logic [LFSR_WIDTH-1:0] state_next
);

    function automatic logic [LFSR_WIDTH-1:0] reflect(input logic [LFSR_WIDTH-1:0] v);
        logic [LFSR_WIDTH-1:0] r;
        for (int i = 0; i < LFSR_WIDTH; i++) begin
            r[i] = v[LFSR_WIDTH-1-i];
        end
        return r;
    endfunction

    localparam logic [LFSR_WIDTH-1:0] POLY_REV = reflect(LFSR_POLY);
    localparam logic [LFSR_WIDTH-1:0] ZERO     = {LFSR_WIDTH{1'b0}};

    logic [LFSR_WIDTH-1:0] state_s;
    logic                  fb_s;

    // Shift every data bit through the Galois register in one cycle.
    always_comb begin
        state_s = state_cur;
        fb_s    = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (REVERSE != 0) begin
                fb_s    = state_s[0] ^ data[i];
                state_s = {1'b0, state_s[LFSR_WIDTH-1:1]} ^ (fb_s ? POLY_REV : ZERO);
            end else begin
                fb_s    = state_s[LFSR_WIDTH-1] ^ data[DATA_WIDTH-1-i];
                state_s = {state_s[LFSR_WIDTH-2:0], 1'b0} ^ (fb_s ? LFSR_POLY : ZERO);
            end
        end
    end

    assign state_next = state_s;

endmodule

// File: rtl/axis_eth_fcs_param.sv
// AXI4-Stream Ethernet FCS tap: computes CRC-32 per frame, reports it one
// cycle after tlast with keep-error / check status and saturating counters.
// Optional build macro FCS_CHECK_EN: compare the post-FCS CRC register to
// the CRC-32 residue and report the result on output_fcs_ok.
module axis_eth_fcs_param #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic [31:0]           output_fcs,
    output logic                  output_fcs_valid,
    output logic                  output_fcs_ok,
    output logic                  output_keep_err,
    output logic [CNT_WIDTH-1:0]  frame_count,
    output logic [CNT_WIDTH-1:0]  error_count
);
    import eth_fcs_pkg::*;

    localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1'b1);
    localparam logic [KEEP_WIDTH-1:0] KEEP_ALL = {KEEP_WIDTH{1'b1}};

    logic [31:0]           crc_state_r;
    logic                  keep_err_r;
    frame_state_e          state_r;
    frame_state_e          state_next_s;
    logic                  frame_start_s;
    logic [31:0]           crc_lane_s [KEEP_WIDTH];
    logic [KEEP_MAX-1:0]   keep_ext_s;
    logic [6:0]            n_s;
    logic [KEEP_WIDTH-1:0] keep_mask_s;
    logic [31:0]           crc_sel_s;
    logic                  beat_keep_err_s;
    logic                  keep_err_acc_s;
    logic                  fcs_ok_s;
    logic                  frame_err_s;

    assign s_axis_tready = 1'b1;

    // One CRC lane per possible byte count; lane i covers bytes 0..i.
    for (genvar i = 0; i < KEEP_WIDTH; i++) begin : g_lane
        lfsr #(
            .LFSR_WIDTH (32),
            .LFSR_POLY  (CRC32_POLY),
            .REVERSE    (1),
            .DATA_WIDTH (8 * (i + 1))
        ) u_lfsr (
            .data       (s_axis_tdata[8*(i+1)-1:0]),
            .state_cur  (crc_state_r),
            .state_next (crc_lane_s[i])
        );
    end

    // Byte count, contiguity mask and lane selection for the current beat.
    always_comb begin
        keep_ext_s                   = {KEEP_MAX{1'b0}};
        keep_ext_s[KEEP_WIDTH-1:0]   = s_axis_tkeep;
        n_s                          = keep_to_count(keep_ext_s);
        keep_mask_s                  = {KEEP_WIDTH{1'b0}};
        crc_sel_s                    = crc_state_r;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            keep_mask_s[i] = (7'(i) < n_s);
            crc_sel_s      = (n_s == 7'(i + 1)) ? crc_lane_s[i] : crc_sel_s;
        end
        if (s_axis_tlast) begin
            beat_keep_err_s = (n_s == 7'd0) || (s_axis_tkeep != keep_mask_s);
        end else begin
            beat_keep_err_s = (s_axis_tkeep != KEEP_ALL);
        end
    end

    // Frame FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= FRAME_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Frame FSM next state: tlast always closes the frame.
    always_comb begin
        state_next_s = state_r;
        if (s_axis_tvalid && s_axis_tlast) begin
            state_next_s = FRAME_IDLE;
        end else if (s_axis_tvalid) begin
            state_next_s = FRAME_IN;
        end else begin
            state_next_s = state_r;
        end
    end

    // Frame FSM outputs: a beat in IDLE opens a new frame and drops stale flags.
    always_comb begin
        frame_start_s  = s_axis_tvalid && (state_r == FRAME_IDLE);
        keep_err_acc_s = (frame_start_s ? 1'b0 : keep_err_r) | beat_keep_err_s;
    end

`ifdef FCS_CHECK_EN
    assign fcs_ok_s = (crc_sel_s == CRC32_RESIDUE) & ~s_axis_tuser;
`else
    assign fcs_ok_s = 1'b1;
`endif

    assign frame_err_s = s_axis_tuser | keep_err_acc_s | ~fcs_ok_s;

    // CRC accumulation and per-frame result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_state_r      <= CRC32_INIT;
            keep_err_r       <= 1'b0;
            output_fcs       <= 32'h0000_0000;
            output_fcs_valid <= 1'b0;
            output_fcs_ok    <= 1'b0;
            output_keep_err  <= 1'b0;
        end else begin
            output_fcs_valid <= 1'b0;
            if (s_axis_tvalid && s_axis_tlast) begin
                crc_state_r      <= CRC32_INIT;
                keep_err_r       <= 1'b0;
                output_fcs       <= ~crc_sel_s;
                output_fcs_valid <= 1'b1;
                output_fcs_ok    <= fcs_ok_s;
                output_keep_err  <= keep_err_acc_s;
            end else if (s_axis_tvalid) begin
                crc_state_r      <= crc_lane_s[KEEP_WIDTH-1];
                keep_err_r       <= keep_err_acc_s;
            end else begin
                crc_state_r      <= crc_state_r;
                keep_err_r       <= keep_err_r;
            end
        end
    end

    // Saturating frame and error statistics, updated with the result pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_count <= {CNT_WIDTH{1'b0}};
            error_count <= {CNT_WIDTH{1'b0}};
        end else if (s_axis_tvalid && s_axis_tlast) begin
            if (frame_count != CNT_MAX) begin
                frame_count <= frame_count + CNT_ONE;
            end else begin
                frame_count <= frame_count;
            end
            if (frame_err_s && (error_count != CNT_MAX)) begin
                error_count <= error_count + CNT_ONE;
            end else begin
                error_count <= error_count;
            end
        end else begin
            frame_count <= frame_count;
            error_count <= error_count;
        end
    end

endmodule

// File: tb/tb_axis_eth_fcs_param.sv
// Self-checking bench for axis_eth_fcs_param: a bit-serial CRC-32 model
// pushes expected per-frame results to a scoreboard, a monitor pops them on
// every output pulse. A second, 8-bit / 4-bit-counter instance covers the
// narrow width and counter saturation.
module tb_axis_eth_fcs_param;

`ifdef FCS_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] fcs;
        logic        ok;
        logic        kerr;
        logic [31:0] fc;
        logic [31:0] ec;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tvalid, tlast, tuser;
    logic        tready;
    logic [31:0] fcs;
    logic        fcs_valid, fcs_ok, keep_err;
    logic [31:0] frame_count, error_count;

    logic [7:0]  n_tdata;
    logic [0:0]  n_tkeep;
    logic        n_tvalid, n_tlast, n_tuser;
    logic        n_tready;
    logic [31:0] n_fcs;
    logic        n_valid, n_ok, n_kerr;
    logic [3:0]  n_frame_count, n_error_count;

    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;
    exp_t sb[$];
    logic [31:0] m_crc = 32'hFFFFFFFF;
    logic        m_kerr = 1'b0;
    logic [31:0] m_fc = 32'h0;
    logic [31:0] m_ec = 32'h0;

    always #5 clk = ~clk;

    axis_eth_fcs_param #(.DATA_WIDTH(64), .KEEP_WIDTH(8), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tvalid(tvalid),
        .s_axis_tready(tready), .s_axis_tlast(tlast), .s_axis_tuser(tuser),
        .output_fcs(fcs), .output_fcs_valid(fcs_valid), .output_fcs_ok(fcs_ok),
        .output_keep_err(keep_err), .frame_count(frame_count), .error_count(error_count)
    );

    axis_eth_fcs_param #(.DATA_WIDTH(8), .KEEP_WIDTH(1), .CNT_WIDTH(4)) dut_narrow (
        .clk(clk), .rst(rst),
        .s_axis_tdata(n_tdata), .s_axis_tkeep(n_tkeep), .s_axis_tvalid(n_tvalid),
        .s_axis_tready(n_tready), .s_axis_tlast(n_tlast), .s_axis_tuser(n_tuser),
        .output_fcs(n_fcs), .output_fcs_valid(n_valid), .output_fcs_ok(n_ok),
        .output_keep_err(n_kerr), .frame_count(n_frame_count), .error_count(n_error_count)
    );

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r[0] ^ b[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    // Scoreboard monitor: every pulse must match the oldest expected frame.
    always @(negedge clk) begin
        exp_t e;
        if (fcs_valid === 1'b1) begin
            pulses++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse fcs=%h", fcs);
            end else begin
                e = sb.pop_front();
                if (fcs !== e.fcs) begin
                    errors++;
                    $display("FAIL sb_fcs got %h exp %h", fcs, e.fcs);
                end
                checks++;
                if (fcs_ok !== e.ok) begin
                    errors++;
                    $display("FAIL sb_ok got %b exp %b", fcs_ok, e.ok);
                end
                checks++;
                if (keep_err !== e.kerr) begin
                    errors++;
                    $display("FAIL sb_keep_err got %b exp %b", keep_err, e.kerr);
                end
                checks++;
                if (frame_count !== e.fc) begin
                    errors++;
                    $display("FAIL sb_frame_count got %0d exp %0d", frame_count, e.fc);
                end
                checks++;
                if (error_count !== e.ec) begin
                    errors++;
                    $display("FAIL sb_error_count got %0d exp %0d", error_count, e.ec);
                end
            end
        end
    end

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k,
                             input logic last, input logic user);
        int         n;
        logic       run;
        logic [7:0] mask;
        exp_t       e;
        n = 0;
        run = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (run && k[i]) n++;
            else run = 1'b0;
        end
        mask = (n == 0) ? 8'h00 : (8'hFF >> (8 - n));
        if (!last) begin
            if (k != 8'hFF) m_kerr = 1'b1;
            for (int i = 0; i < 8; i++) m_crc = crc_byte(m_crc, d[8*i +: 8]);
        end else begin
            if (n == 0 || k != mask) m_kerr = 1'b1;
            for (int i = 0; i < n; i++) m_crc = crc_byte(m_crc, d[8*i +: 8]);
            e.fcs  = ~m_crc;
            e.ok   = CHECK_EN ? ((m_crc == 32'hDEBB20E3) && !user) : 1'b1;
            e.kerr = m_kerr;
            if (m_fc != 32'hFFFFFFFF) m_fc++;
            if ((user || m_kerr || !e.ok) && m_ec != 32'hFFFFFFFF) m_ec++;
            e.fc = m_fc;
            e.ec = m_ec;
            sb.push_back(e);
            m_crc  = 32'hFFFFFFFF;
            m_kerr = 1'b0;
        end
        @(negedge clk);
        tdata = d; tkeep = k; tvalid = 1'b1; tlast = last; tuser = user;
    endtask

    task automatic send_frame(input logic [7:0] q[$], input logic user);
        int          pos;
        int          cnt;
        logic [63:0] d;
        logic [7:0]  k;
        pos = 0;
        while (pos < q.size()) begin
            d = 64'h0;
            k = 8'h00;
            cnt = (q.size() - pos > 8) ? 8 : q.size() - pos;
            for (int i = 0; i < cnt; i++) begin
                d[8*i +: 8] = q[pos + i];
                k[i] = 1'b1;
            end
            pos += cnt;
            send_beat(d, k, pos == q.size(), user);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        tvalid = 1'b0; tlast = 1'b0; tkeep = 8'h00; tuser = 1'b0; tdata = 64'h0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain missing_pulses=%0d", sb.size());
            sb.delete();
        end
    endtask

    function automatic void model_reset();
        m_crc = 32'hFFFFFFFF; m_kerr = 1'b0; m_fc = 32'h0; m_ec = 32'h0;
    endfunction

    function automatic void digits(output logic [7:0] q[$]);
        q.delete();
        for (int i = 0; i < 9; i++) q.push_back(8'(49 + i));
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (fcs !== 32'h0 || fcs_valid !== 1'b0 || fcs_ok !== 1'b0 || keep_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs fcs=%h v=%b ok=%b ke=%b exp 0", fcs, fcs_valid, fcs_ok, keep_err);
        end
        checks++;
        if (frame_count !== 32'h0 || error_count !== 32'h0 || tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_counters fc=%0d ec=%0d rdy=%b exp 0 0 1", frame_count, error_count, tready);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_known_vector();
        logic [7:0] q[$];
        digits(q);
        send_frame(q, 1'b0);
        idle();
        checks++;
        if (fcs_valid !== 1'b1 || fcs !== 32'hCBF43926 || frame_count !== 32'd1) begin
            errors++;
            $display("FAIL known_vector v=%b fcs=%h fc=%0d exp 1 cbf43926 1", fcs_valid, fcs, frame_count);
        end
        @(negedge clk);
        checks++;
        if (fcs_valid !== 1'b0 || fcs !== 32'hCBF43926) begin
            errors++;
            $display("FAIL hold_after_pulse v=%b fcs=%h exp 0 cbf43926", fcs_valid, fcs);
        end
        drain();
    endtask

    task automatic test_fcs_check();
        logic [7:0] q[$];
        digits(q);
        q.push_back(8'h26); q.push_back(8'h39); q.push_back(8'hF4); q.push_back(8'hCB);
        send_frame(q, 1'b0);
        idle();
        checks++;
        if (fcs_ok !== 1'b1) begin
            errors++;
            $display("FAIL fcs_good_ok got %b exp 1", fcs_ok);
        end
        q[12] = 8'hCA;
        send_frame(q, 1'b0);
        idle();
        checks++;
        if (fcs_ok !== !CHECK_EN) begin
            errors++;
            $display("FAIL fcs_flip_ok got %b exp %b", fcs_ok, !CHECK_EN);
        end
        q[12] = 8'hCB;
        send_frame(q, 1'b1);
        idle();
        drain();
    endtask

    task automatic test_keep_err();
        send_beat(64'h0807060504030201, 8'hFF, 1'b0, 1'b0);
        send_beat(64'h00000000AA33CC11, 8'h0D, 1'b1, 1'b0);
        idle();
        checks++;
        if (keep_err !== 1'b1) begin
            errors++;
            $display("FAIL keep_noncontig got %b exp 1", keep_err);
        end
        send_beat(64'h1122334455667788, 8'h7F, 1'b0, 1'b0);
        send_beat(64'h99AABBCCDDEEFF00, 8'h03, 1'b1, 1'b0);
        send_beat(64'h0123456789ABCDEF, 8'h00, 1'b1, 1'b0);
        send_beat(64'hDEADBEEF00C0FFEE, 8'h3F, 1'b1, 1'b0);
        idle();
        drain();
    endtask

    task automatic test_back_to_back();
        int p0;
        drain();
        p0 = pulses;
        for (int i = 0; i < 100; i++) begin
            send_beat({$urandom(), $urandom()}, 8'hFF, 1'b1, 1'b0);
        end
        idle();
        drain();
        checks++;
        if (pulses - p0 != 100) begin
            errors++;
            $display("FAIL back_to_back_pulses got %0d exp 100", pulses - p0);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] q[$];
        send_beat(64'h5555AAAA5555AAAA, 8'hFF, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1; tvalid = 1'b0; tlast = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        m_crc = 32'hFFFFFFFF;
        digits(q);
        send_frame(q, 1'b0);
        idle();
        checks++;
        if (fcs !== 32'hCBF43926 || frame_count !== 32'd1 || fcs_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_midframe fcs=%h fc=%0d v=%b exp cbf43926 1 1", fcs, frame_count, fcs_valid);
        end
        drain();
    endtask

    task automatic test_narrow();
        logic [7:0] q[$];
        int         seen;
        digits(q);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            n_tdata = q[i]; n_tkeep = 1'b1; n_tvalid = 1'b1; n_tlast = (i == 8); n_tuser = 1'b0;
        end
        @(negedge clk);
        n_tvalid = 1'b0; n_tlast = 1'b0;
        checks++;
        if (n_valid !== 1'b1 || n_fcs !== 32'hCBF43926) begin
            errors++;
            $display("FAIL narrow_fcs v=%b fcs=%h exp 1 cbf43926", n_valid, n_fcs);
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (n_valid === 1'b1) seen++;
            n_tdata = 8'(i); n_tvalid = 1'b1; n_tlast = 1'b1;
        end
        @(negedge clk);
        n_tvalid = 1'b0; n_tlast = 1'b0;
        if (n_valid === 1'b1) seen++;
        checks++;
        if (seen != 20 || n_frame_count !== 4'hF) begin
            errors++;
            $display("FAIL narrow_saturate pulses=%0d fc=%0d exp 20 15", seen, n_frame_count);
        end
        checks++;
        if (n_error_count !== (CHECK_EN ? 4'hF : 4'h0)) begin
            errors++;
            $display("FAIL narrow_error_count got %0d exp %0d", n_error_count, CHECK_EN ? 15 : 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        tdata = 64'h0; tkeep = 8'h00; tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
        n_tdata = 8'h00; n_tkeep = 1'b0; n_tvalid = 1'b0; n_tlast = 1'b0; n_tuser = 1'b0;
        test_reset();
        test_known_vector();
        test_fcs_check();
        test_keep_err();
        test_back_to_back();
        test_reset_midframe();
        test_narrow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
